// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: FSM states, opcodes,
// ALUOp encoding (also consumed by the ALU control decoder) and the control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ORI_EXEC = 4'd10,
        S_ORI_WB   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_OR    = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational control-word decode from current state (plus opcode in DECODE and
// mem_ready in the memory-wait states, so enables only fire on the completing cycle).
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic [5:0]        opcode_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t cw;

    always_comb begin
        cw = '0;
        case (state_i)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALUOP_ADD;
                cw.pc_source = PCSRC_ALU;
                cw.ir_write  = mem_ready_i;
                cw.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                cw.alu_src_b  = SRCB_IMM4;
                cw.alu_op     = ALUOP_ADD;
                cw.illegal_op = ~is_legal_op(opcode_i);
            end
            S_MEM_ADDR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                cw.mem_write  = 1'b1;
                cw.i_or_d     = 1'b1;
                cw.instr_done = mem_ready_i;
            end
            S_R_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                cw.reg_write  = 1'b1;
                cw.reg_dst    = 1'b1;
                cw.instr_done = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a     = 1'b1;
                cw.alu_src_b     = SRCB_REG;
                cw.alu_op        = ALUOP_SUB;
                cw.pc_write_cond = 1'b1;
                cw.pc_source     = PCSRC_ALUOUT;
                cw.instr_done    = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write   = 1'b1;
                cw.pc_source  = PCSRC_JUMP;
                cw.instr_done = 1'b1;
            end
            S_ORI_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.zero_ext  = 1'b1;
                cw.alu_op    = ALUOP_OR;
            end
            S_ORI_WB: begin
                cw.reg_write  = 1'b1;
                cw.instr_done = 1'b1;
            end
            default: cw = '0;
        endcase
    end

    assign ctrl_o = cw;

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath; FETCH/MEM_RD/MEM_WR stall
// with requests held while mem_ready is low. Reset masks every write enable and pulse.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_vec;
    ctrl_t             cw_raw, cw;

    // zero is qualified by pc_write_cond in the datapath, not by the FSM
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ORI:       state_d = S_ORI_EXEC;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_d = S_R_WB;
            S_ORI_EXEC: state_d = S_ORI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    mips_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_vec)
    );

    assign cw_raw = ctrl_t'(ctrl_vec);

    always_comb begin
        cw = cw_raw;
        if (reset) begin
            cw.pc_write      = 1'b0;
            cw.pc_write_cond = 1'b0;
            cw.ir_write      = 1'b0;
            cw.reg_write     = 1'b0;
            cw.mem_write     = 1'b0;
            cw.instr_done    = 1'b0;
            cw.illegal_op    = 1'b0;
        end
    end

    assign pc_write      = cw.pc_write;
    assign pc_write_cond = cw.pc_write_cond;
    assign i_or_d        = cw.i_or_d;
    assign mem_read      = cw.mem_read;
    assign mem_write     = cw.mem_write;
    assign ir_write      = cw.ir_write;
    assign mem_to_reg    = cw.mem_to_reg;
    assign reg_dst       = cw.reg_dst;
    assign reg_write     = cw.reg_write;
    assign alu_src_a     = cw.alu_src_a;
    assign alu_src_b     = cw.alu_src_b;
    assign zero_ext      = cw.zero_ext;
    assign alu_op        = cw.alu_op;
    assign pc_source     = cw.pc_source;
    assign instr_done    = cw.instr_done;
    assign illegal_op    = cw.illegal_op;
    assign state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed vector table followed by randomized instruction streams checked against
// a per-instruction state-plan model.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, zero_ext;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .illegal_op(illegal_op), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic       zero_ext;
        logic [1:0] alu_op, pc_source;
        logic       instr_done, illegal_op;
        logic [3:0] st;
    } sig_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic       mr;
        logic       chk;
        state_t     st;
        logic [4:0] we;   // {pc_write, pc_write_cond, ir_write, reg_write, mem_write}
        logic [1:0] pl;   // {instr_done, illegal_op}
        logic [1:0] aop;
    } vec_t;

    vec_t   tv[$];
    int     checks = 0;
    int     failures = 0;

    task automatic row(input logic rst, input logic [5:0] op, input logic z, input logic mr,
                       input logic chk, input state_t st, input logic [4:0] we,
                       input logic [1:0] pl, input logic [1:0] aop);
        vec_t v;
        v = '{rst, op, z, mr, chk, st, we, pl, aop};
        tv.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    function automatic sig_t actual();
        sig_t a;
        a = '{pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, zero_ext,
              alu_op, pc_source, instr_done, illegal_op, state};
        return a;
    endfunction

    // Expected control outputs for a given step of an instruction
    function automatic sig_t expect_for(input state_t s, input logic mr, input logic rst,
                                        input logic [5:0] op);
        sig_t e;
        e = '0;
        e.st = s;
        case (s)
            S_FETCH:    begin e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 2'b01;
                              e.ir_write = mr; e.pc_write = mr; end
            S_DECODE:   begin e.alu_src_b = 2'b11; e.alu_op = 2'b01;
                              e.illegal_op = !(op inside {6'b000000, 6'b100011, 6'b101011,
                                                          6'b000100, 6'b000010, 6'b001101}); end
            S_MEM_ADDR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b01; end
            S_MEM_RD:   begin e.mem_read = 1'b1; e.i_or_d = 1'b1; end
            S_MEM_WB:   begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1; end
            S_MEM_WR:   begin e.mem_write = 1'b1; e.i_or_d = 1'b1; e.instr_done = mr; end
            S_R_EXEC:   begin e.alu_src_a = 1'b1; end
            S_R_WB:     begin e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1; end
            S_BRANCH:   begin e.alu_src_a = 1'b1; e.alu_op = 2'b11; e.pc_write_cond = 1'b1;
                              e.pc_source = 2'b01; e.instr_done = 1'b1; end
            S_JUMP:     begin e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1; end
            S_ORI_EXEC: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.zero_ext = 1'b1;
                              e.alu_op = 2'b10; end
            S_ORI_WB:   begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
            default:    e = '0;
        endcase
        if (rst) begin
            e.pc_write = 1'b0; e.pc_write_cond = 1'b0; e.ir_write = 1'b0;
            e.reg_write = 1'b0; e.mem_write = 1'b0; e.instr_done = 1'b0; e.illegal_op = 1'b0;
        end
        return e;
    endfunction

    // Sequence of steps an instruction walks through (memory waits repeat a step)
    task automatic build_plan(input logic [5:0] op, output state_t q[$]);
        q = {S_FETCH, S_DECODE};
        case (op)
            6'b000000: begin q.push_back(S_R_EXEC); q.push_back(S_R_WB); end
            6'b100011: begin q.push_back(S_MEM_ADDR); q.push_back(S_MEM_RD); q.push_back(S_MEM_WB); end
            6'b101011: begin q.push_back(S_MEM_ADDR); q.push_back(S_MEM_WR); end
            6'b000100: q.push_back(S_BRANCH);
            6'b000010: q.push_back(S_JUMP);
            6'b001101: begin q.push_back(S_ORI_EXEC); q.push_back(S_ORI_WB); end
            default:   ;
        endcase
    endtask

    initial begin
        logic [5:0] legal [6];
        state_t     plan[$];
        logic [5:0] cur_op;
        logic       r_mr, r_rst;
        sig_t       a, e;

        legal = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI};
        reset = 1'b1; opcode = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;

        row(1'b1, OP_RTYPE, 1'b0, 1'b1, 1'b0, S_FETCH,    5'b00000, 2'b00, 2'b01);
        row(1'b1, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_FETCH,    5'b00000, 2'b00, 2'b01);
        row(1'b1, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_FETCH,    5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_R_EXEC,   5'b00000, 2'b00, 2'b00);
        row(1'b0, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_R_WB,     5'b00010, 2'b10, 2'b00);
        row(1'b0, OP_LW,    1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_LW,    1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_LW,    1'b0, 1'b0, 1'b1, S_MEM_ADDR, 5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_LW,    1'b0, 1'b0, 1'b1, S_MEM_RD,   5'b00000, 2'b00, 2'b00);
        row(1'b0, OP_LW,    1'b0, 1'b0, 1'b1, S_MEM_RD,   5'b00000, 2'b00, 2'b00);
        row(1'b0, OP_LW,    1'b0, 1'b1, 1'b1, S_MEM_RD,   5'b00000, 2'b00, 2'b00);
        row(1'b0, OP_LW,    1'b0, 1'b1, 1'b1, S_MEM_WB,   5'b00010, 2'b10, 2'b00);
        row(1'b0, OP_BEQ,   1'b1, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_BEQ,   1'b1, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_BEQ,   1'b1, 1'b1, 1'b1, S_BRANCH,   5'b01000, 2'b10, 2'b11);
        row(1'b0, OP_BEQ,   1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_BEQ,   1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_BEQ,   1'b0, 1'b1, 1'b1, S_BRANCH,   5'b01000, 2'b10, 2'b11);
        row(1'b0, 6'h3f,    1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, 6'h3f,    1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b01, 2'b01);
        row(1'b0, OP_SW,    1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_SW,    1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_SW,    1'b0, 1'b1, 1'b1, S_MEM_ADDR, 5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_SW,    1'b0, 1'b0, 1'b1, S_MEM_WR,   5'b00001, 2'b00, 2'b00);
        row(1'b1, OP_SW,    1'b0, 1'b0, 1'b1, S_MEM_WR,   5'b00000, 2'b00, 2'b00);
        row(1'b0, OP_ORI,   1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_ORI,   1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_ORI,   1'b0, 1'b1, 1'b1, S_ORI_EXEC, 5'b00000, 2'b00, 2'b10);
        row(1'b0, OP_ORI,   1'b0, 1'b1, 1'b1, S_ORI_WB,   5'b00010, 2'b10, 2'b00);
        row(1'b0, OP_J,     1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);
        row(1'b0, OP_J,     1'b0, 1'b1, 1'b1, S_DECODE,   5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_J,     1'b0, 1'b1, 1'b1, S_JUMP,     5'b10000, 2'b10, 2'b00);
        row(1'b0, OP_RTYPE, 1'b0, 1'b0, 1'b1, S_FETCH,    5'b00000, 2'b00, 2'b01);
        row(1'b0, OP_RTYPE, 1'b0, 1'b1, 1'b1, S_FETCH,    5'b10100, 2'b00, 2'b01);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            reset = tv[i].rst; opcode = tv[i].op; zero = tv[i].z; mem_ready = tv[i].mr;
            #1;
            if (tv[i].chk) begin
                a = actual();
                check("vec_state", i, 32'(state), 32'(tv[i].st));
                check("vec_enables", i, 32'({pc_write, pc_write_cond, ir_write, reg_write, mem_write}),
                      32'(tv[i].we));
                check("vec_pulses", i, 32'({instr_done, illegal_op}), 32'(tv[i].pl));
                check("vec_alu_op", i, 32'(alu_op), 32'(tv[i].aop));
                check("vec_model", i, 32'(a),
                      32'(expect_for(tv[i].st, tv[i].mr, tv[i].rst, tv[i].op)));
            end
        end

        // resynchronise the model with a reset cycle before the random stream
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        plan.delete();
        cur_op = OP_RTYPE;

        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (plan.size() == 0) begin
                if ($urandom_range(0, 6) < 6) cur_op = legal[$urandom_range(0, 5)];
                else cur_op = 6'($urandom_range(0, 63));
                build_plan(cur_op, plan);
            end
            r_mr  = ($urandom_range(0, 3) != 0);
            r_rst = ($urandom_range(0, 59) == 0);
            reset = r_rst; opcode = cur_op; zero = 1'($urandom); mem_ready = r_mr;
            #1;
            e = expect_for(plan[0], r_mr, r_rst, cur_op);
            check("rand_model", c, 32'(actual()), 32'(e));
            @(posedge clk);
            if (r_rst) plan.delete();
            else if (!((plan[0] inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && !r_mr))
                void'(plan.pop_front());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
